// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / program-counter stage: one req/ack fetch per instruction,
// valid/ready hand-off to decode, branch-aware next-PC and a sticky fetch timeout.
module fetch_pc_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  PCsrc,
  input  logic [ADDR_WIDTH-1:0] ImmOp,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  fetch_err
);

  localparam int             CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  TLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   pc_reg;
  logic [ADDR_WIDTH-1:0]   pc_next;
  logic [DATA_WIDTH-1:0]   instr_reg;
  logic                    req_reg;
  logic                    valid_reg;
  logic                    err_reg;
  logic [CW-1:0]           tmo_cnt_reg;
  logic                    handshake;
  logic                    tmo_hit;

  assign handshake = valid_reg & instr_ready;
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt_reg == TLAST);
  // Unsigned modulo add; a two's-complement ImmOp falls out of the same adder.
  assign pc_next   = PCsrc ? (pc_reg + ImmOp) : (pc_reg + ADDR_WIDTH'(4));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      instr_reg   <= '0;
      req_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
      tmo_cnt_reg <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (en) begin
            state_reg   <= REQ;
            req_reg     <= 1'b1;
            tmo_cnt_reg <= '0;
          end
        end
        REQ: begin
          // An ack in the same cycle the timeout would fire takes priority.
          if (imem_ack) begin
            instr_reg <= imem_rdata;
            state_reg <= HOLD;
            req_reg   <= 1'b0;
            valid_reg <= 1'b1;
          end else if (tmo_hit) begin
            state_reg <= ERR;
            req_reg   <= 1'b0;
            err_reg   <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        HOLD: begin
          if (handshake) begin
            pc_reg      <= pc_next;
            valid_reg   <= 1'b0;
            tmo_cnt_reg <= '0;
            if (en) begin
              state_reg <= REQ;
              req_reg   <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        ERR: begin
          state_reg <= ERR;
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_reg;
  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;
  assign pc          = pc_reg;
  assign fetch_err   = err_reg;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: driver pushes expected fetch address and
// decoded {instr,pc} into queues, a negedge monitor pops and compares on handshakes.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        PCsrc = 1'b0;
  logic [31:0] ImmOp = '0;
  logic [31:0] pc;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  logic [31:0] addr_q[$];
  logic [63:0] data_q[$];

  fetch_pc_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .TIMEOUT   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .PCsrc      (PCsrc),
    .ImmOp      (ImmOp),
    .pc         (pc),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst && imem_req && imem_ack) begin
      if (addr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_fetch actual=%h expected=none", imem_addr);
      end else begin
        logic [31:0] ea;
        ea = addr_q.pop_front();
        check32("fetch_addr", imem_addr, ea);
        $display("fetch addr=%h rdata=%h", imem_addr, imem_rdata);
      end
    end
    if (!rst && instr_valid && instr_ready) begin
      if (data_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_issue actual=%h/%h expected=none", instr, pc);
      end else begin
        logic [63:0] ed;
        ed = data_q.pop_front();
        check32("issue_instr", instr, ed[63:32]);
        check32("issue_pc", pc, ed[31:0]);
        $display("issue instr=%h pc=%h PCsrc=%b ImmOp=%h", instr, pc, PCsrc, ImmOp);
      end
    end
  end

  // One instruction: wait for REQ, ack after ackd cycles, stall ready for rdy cycles.
  task automatic do_fetch(input logic [31:0] epc, input logic [31:0] rd, input int ackd,
                          input int rdy, input logic br, input logic [31:0] imm, input bit b2b);
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      tick();
      n++;
    end
    if (!imem_req) begin
      checks++; failures++;
      $display("FAIL req_wait actual=no_req expected=req pc=%h", epc);
      return;
    end
    if (b2b) check32("back_to_back", n, 0);
    for (int d = 0; d < ackd; d++) begin
      check32("wait_req", {31'b0, imem_req}, 32'd1);
      check32("wait_addr", imem_addr, epc);
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = rd;
    addr_q.push_back(epc);
    data_q.push_back({rd, epc});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = rd ^ 32'hBAD0_0000;
    for (int r = 0; r < rdy; r++) begin
      check32("stall_valid", {31'b0, instr_valid}, 32'd1);
      check32("stall_instr", instr, rd);
      check32("stall_pc", pc, epc);
      tick();
    end
    instr_ready = 1'b1;
    PCsrc       = br;
    ImmOp       = imm;
    tick();
    instr_ready = 1'b0;
    PCsrc       = 1'b1;
    ImmOp       = 32'h0000_0100;
  endtask

  initial begin
    int n;
    // Reset state with clock running
    repeat (3) tick();
    check32("rst_pc", pc, 32'h0);
    check32("rst_addr", imem_addr, 32'h0);
    check32("rst_req", {31'b0, imem_req}, 32'd0);
    check32("rst_valid", {31'b0, instr_valid}, 32'd0);
    check32("rst_err", {31'b0, fetch_err}, 32'd0);
    check32("rst_instr", instr, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check32("idle_req", {31'b0, imem_req}, 32'd0);
    end
    check32("idle_valid", {31'b0, instr_valid}, 32'd0);

    en = 1'b1;
    //        pc            rdata         ackd rdy br    ImmOp         b2b
    do_fetch(32'h0000_0000, 32'h0000_0013, 0, 0, 1'b0, 32'h0,         1'b0);
    do_fetch(32'h0000_0004, 32'h0010_0093, 0, 0, 1'b0, 32'h0,         1'b1);
    do_fetch(32'h0000_0008, 32'h0020_0113, 0, 0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    do_fetch(32'h0000_0000, 32'h1111_1111, 0, 0, 1'b0, 32'h0,         1'b1);
    do_fetch(32'h0000_0004, 32'h2222_2222, 0, 0, 1'b0, 32'h0,         1'b1);
    do_fetch(32'h0000_0008, 32'h3333_3333, 0, 0, 1'b1, 32'h0000_0010, 1'b1);
    do_fetch(32'h0000_0018, 32'h4444_4444, 3, 4, 1'b0, 32'h0,         1'b1);
    do_fetch(32'h0000_001C, 32'h5555_5555, 0, 0, 1'b1, 32'hFFFF_FFE0, 1'b1);
    do_fetch(32'hFFFF_FFFC, 32'h6666_6666, 0, 0, 1'b0, 32'h0,         1'b1);
    do_fetch(32'h0000_0000, 32'h7777_7777, 2, 1, 1'b0, 32'h0,         1'b1);
    // Ack on the 16th REQ cycle beats the timeout
    do_fetch(32'h0000_0004, 32'h8888_8888, 15, 0, 1'b0, 32'h0,        1'b1);

    // Never ack: exactly 16 REQ cycles, then sticky error
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      tick();
    end
    check32("timeout_req_cycles", n, 16);
    check32("timeout_err", {31'b0, fetch_err}, 32'd1);
    check32("timeout_req_low", {31'b0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    repeat (3) tick();
    imem_ack = 1'b0;
    tick();
    check32("err_sticky", {31'b0, fetch_err}, 32'd1);
    check32("err_pc_frozen", pc, 32'h0000_0008);
    check32("err_req", {31'b0, imem_req}, 32'd0);
    check32("err_valid", {31'b0, instr_valid}, 32'd0);
    $display("timeout req_cycles=%0d fetch_err=%b pc=%h", n, fetch_err, pc);

    // Clear the error, enter REQ, then reset mid-request
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check32("req_after_rst", {31'b0, imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check32("async_rst_req", {31'b0, imem_req}, 32'd0);
    check32("async_rst_err", {31'b0, fetch_err}, 32'd0);
    en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack   = 1'b0;
    tick();
    check32("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    check32("late_ack_instr", instr, 32'h0);
    check32("late_ack_pc", pc, 32'h0);
    check32("late_ack_req", {31'b0, imem_req}, 32'd0);
    $display("reset_mid_req pc=%h instr_valid=%b", pc, instr_valid);

    en = 1'b1;
    do_fetch(32'h0000_0000, 32'h9999_9999, 0, 0, 1'b0, 32'h0, 1'b0);
    tick();
    check32("addr_q_drained", addr_q.size(), 0);
    check32("data_q_drained", data_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
